hazard_sequencer: RTL



---
 rtl/hazard_sequencer_pkg.sv | 23 ++
 rtl/hazard_sequencer_loaduse.sv | 19 +
 rtl/hazard_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared encodings for the hazard sequencer: FSM states, register-specifier width, flush vector.
package hazard_sequencer_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // One bit per pipeline register that can be cleared to a NOP/bubble.
    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
    } flush_t;

    localparam flush_t FLUSH_NONE = '{ifid: 1'b0, idex: 1'b0, exmem: 1'b0};
    localparam flush_t FLUSH_IFID = '{ifid: 1'b1, idex: 1'b0, exmem: 1'b0};
    localparam flush_t FLUSH_ALL  = '{ifid: 1'b1, idex: 1'b1, exmem: 1'b1};

endpackage

// File: rtl/hazard_sequencer_loaduse.sv
// Combinational load-use detector: a load in EX writes a register the ID instruction reads.
module hazard_loaduse_detect
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    output logic                  o_loaduse
);

    // $zero is never a real dependency.
    assign o_loaduse = i_ex_memread && (i_ex_rt != '0) &&
                       ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller with memory-wait hold and watchdog.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned WAIT_MAX   = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_id_jump,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_mem_branch_taken,
    input  logic                  i_mem_busy,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
    output logic                  o_ctrl_enable,
    output logic                  o_idex_flush,
    output logic                  o_exmem_flush,
    output logic                  o_pipe_hold,
    output logic                  o_timeout_err,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_branch_pend;
    logic                w_pend_nxt;
    logic                w_loaduse;
    logic                w_eval_run;
    flush_t              w_flush;

    hazard_loaduse_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_loaduse (
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .i_ex_memread (i_ex_memread),
        .i_ex_rt      (i_ex_rt),
        .o_loaduse    (w_loaduse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_branch_pend <= w_pend_nxt;
        end
    end

    // Next state and Mealy outputs; w_eval_run selects the load-use / jump rules.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_pend_nxt    = r_branch_pend;
        w_eval_run    = 1'b0;
        w_flush       = FLUSH_NONE;
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ctrl_enable = 1'b1;
        o_pipe_hold   = 1'b0;
        o_timeout_err = 1'b0;

        case (r_state)
            RUN: begin
                if (i_mem_busy) begin
                    o_pipe_hold  = 1'b1;
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    w_pend_nxt   = i_mem_branch_taken;
                    w_wait_nxt   = WAIT_W'(1);
                    w_state_nxt  = MEM_WAIT;
                end else if (i_mem_branch_taken) begin
                    w_flush = FLUSH_ALL;
                end else begin
                    w_eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (i_mem_busy) begin
                    o_pipe_hold  = 1'b1;
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    w_pend_nxt   = r_branch_pend | i_mem_branch_taken;
                    w_wait_nxt   = r_wait_cnt + WAIT_W'(1);
                    // Trip once WAIT_MAX consecutive busy cycles have been seen.
                    if (w_wait_nxt == WAIT_W'(WAIT_MAX)) begin
                        w_state_nxt = ERROR;
                    end
                end else begin
                    w_pend_nxt  = 1'b0;
                    w_wait_nxt  = '0;
                    w_state_nxt = RUN;
                    // A branch still resolving in MEM on release is the same pending redirect.
                    if (r_branch_pend || i_mem_branch_taken) begin
                        w_flush = FLUSH_ALL;
                    end else begin
                        w_eval_run = 1'b1;
                    end
                end
            end
            ERROR: begin
                o_pipe_hold   = 1'b1;
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_ctrl_enable = 1'b0;
                o_timeout_err = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        if (w_eval_run) begin
            if (w_loaduse) begin
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_ctrl_enable = 1'b0;
            end else if (i_id_jump) begin
                w_flush = FLUSH_IFID;
            end
        end
    end

    assign o_ifid_flush  = w_flush.ifid;
    assign o_idex_flush  = w_flush.idex;
    assign o_exmem_flush = w_flush.exmem;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;

    // Outside ERROR a dropped ctrl_enable only ever means a load-use bubble; every flush event clears IF/ID.
    assign w_stall_inc = !o_ctrl_enable && (r_state != ERROR);
    assign w_flush_inc = w_flush.ifid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
